// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU store bus.
// Stores to the 16-byte window push bytes into a TX FIFO or clear the sticky
// overflow flag. A serializer drains the FIFO as back-to-back frames. The
// decode, read data and RAM write gating are combinational so that the
// single-cycle CPU read path sees them in the same cycle.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0200_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  input  logic [1:0]  Store,
  output logic        mmio_hit,
  output logic [31:0] mmio_rdata,
  output logic        dmem_we,
  output logic        uart_tx,
  output logic        tx_irq
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int AW1 = AW + 1;
  localparam int BW  = $clog2(CLKS_PER_BIT);

  localparam logic [AW1-1:0] DEPTH_C   = AW1'(FIFO_DEPTH);
  localparam logic [AW1-1:0] COUNT_ONE = AW1'(1);
  localparam logic [AW-1:0]  PTR_ONE   = AW'(1);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]  BAUD_ONE  = BW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW1-1:0]  count;
  logic            overflow;

  logic            hit;
  logic [1:0]      offset;
  logic            empty;
  logic            full;
  logic            baud_end;
  logic            pop;
  logic            push_req;
  logic            push;
  logic            clr_ovf;
  logic [31:0]     count_wide;
  logic [3:0]      cnt_field;
  logic [31:0]     status;

  // The store width, the byte lane bits of the address and the upper data
  // bits carry no meaning for this window.
  logic            unused_inputs;
  assign unused_inputs = ^{Store, Mem_WrAddr[1:0], Mem_WrData[31:8]};

  // Window decode and RAM write gating.
  assign hit      = (Mem_WrAddr[31:4] == BASE_ADDR[31:4]);
  assign offset   = Mem_WrAddr[3:2];
  assign mmio_hit = hit;
  assign dmem_we  = MemWrite & ~hit;

  // FIFO flags and handshakes. A pop happens whenever the serializer can
  // accept a byte: from IDLE, or on the last cycle of STOP. A push into a
  // full FIFO still succeeds when a pop frees a slot on the same edge.
  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign baud_end = (baud_cnt == BAUD_LAST);
  assign pop      = ~empty & ((state == IDLE) | ((state == STOP) & baud_end));
  assign push_req = ~reset & MemWrite & hit & (offset == 2'd0);
  assign push     = push_req & (~full | pop);
  assign clr_ovf  = MemWrite & hit & (offset == 2'd1) & Mem_WrData[3];

  assign tx_irq   = empty & (state == IDLE);

  // STATUS assembly, with the count field saturating at 15.
  assign count_wide = 32'(count);
  assign cnt_field  = (count_wide > 32'd15) ? 4'hF : count_wide[3:0];
  assign status     = {24'h0, cnt_field, overflow, empty, full, (state != IDLE)};

  // Read mux for the window: only STATUS returns non-zero data.
  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned and a latch is never inferred.
  always_comb begin
    mmio_rdata = 32'h0;
    if (hit && (offset == 2'd1)) begin
      mmio_rdata = status;
    end
  end

  // FIFO storage; stale contents are harmless because the pointers and
  // count define what is valid.
  // NOTE: the storage array has no reset, which keeps it mappable to plain
  // RAM; flushing is done by resetting the pointers and count only.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= Mem_WrData[7:0];
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
      if (push_req && full && !pop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // Serializer: start bit, 8 data bits LSB first, stop bit, each held for
  // CLKS_PER_BIT cycles, with uart_tx registered and chained frames having
  // no idle gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      uart_tx  <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (pop) begin
            shreg    <= mem[rd_ptr];
            baud_cnt <= '0;
            uart_tx  <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            uart_tx  <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shreg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shreg   <= mem[rd_ptr];
              uart_tx <= 1'b0;
              state   <= START;
            end else begin
              state   <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A queue-based reference model tracks the FIFO contents and the position
// inside the current 40-cycle frame; directed sequences check the
// latency, chaining, overflow, decode and reset corners against constants.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE    = 32'h0200_0000;
  localparam logic [27:0] BASE_HI = 28'(BASE >> 4);
  localparam int          CPB     = 4;
  localparam int          DEPTH   = 4;
  localparam int          FRAME   = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] Mem_WrAddr = BASE + 32'h4;
  logic [31:0] Mem_WrData = 32'h0;
  logic [1:0]  Store = 2'b00;
  logic        mmio_hit;
  logic [31:0] mmio_rdata;
  logic        dmem_we;
  logic        uart_tx;
  logic        tx_irq;

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .Mem_WrAddr(Mem_WrAddr),
    .Mem_WrData(Mem_WrData),
    .Store     (Store),
    .mmio_hit  (mmio_hit),
    .mmio_rdata(mmio_rdata),
    .dmem_we   (dmem_we),
    .uart_tx   (uart_tx),
    .tx_irq    (tx_irq)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: queued bytes, byte in flight, cycle within frame.
  logic [7:0] q[$];
  logic [7:0] cur = 8'h0;
  int         pos = 0;
  bit         active = 1'b0;
  bit         ovf = 1'b0;
  logic       exp_tx = 1'b1;
  bit         comb_ok = 1'b0;

  // Post-edge samples of the most recent directed sequence.
  logic        log_tx[$];
  logic        log_irq[$];
  logic [31:0] log_rd[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_hit;
    logic        exp_we;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs[11];
  logic [63:0] exp_f;
  logic [63:0] act_f;
  logic [7:0]  fbyte;
  int          bad;
  int          bi;
  int          sel;
  int          rate;
  logic [31:0] r_addr;
  logic        r_we;
  logic        r_rst;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_status();
    int         n;
    logic [3:0] c;
    n = q.size();
    c = (n > 15) ? 4'hF : 4'(n);
    return {24'h0, c, ovf, (n == 0), (n == DEPTH), active};
  endfunction

  function automatic logic model_irq();
    return (q.size() == 0) && !active;
  endfunction

  // Line level of the frame in flight: start 0, data LSB first, stop 1.
  function automatic logic frame_bit();
    int b;
    if (!active) return 1'b1;
    b = pos / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur[b-1];
  endfunction

  // Advance the model by one clock edge using the inputs being driven.
  task automatic model_step();
    bit hit;
    bit push_req;
    bit clr;
    bit pop;
    hit = (Mem_WrAddr[31:4] == BASE_HI);
    if (reset) begin
      q.delete();
      active = 1'b0;
      pos    = 0;
      ovf    = 1'b0;
    end else begin
      push_req = MemWrite && hit && (Mem_WrAddr[3:2] == 2'd0);
      clr      = MemWrite && hit && (Mem_WrAddr[3:2] == 2'd1) && Mem_WrData[3];
      pop      = 1'b0;
      if (active) begin
        if (pos == FRAME - 1) begin
          active = 1'b0;
          pop    = (q.size() > 0);
        end else begin
          pos++;
        end
      end else begin
        pop = (q.size() > 0);
      end
      if (pop) begin
        cur    = q.pop_front();
        active = 1'b1;
        pos    = 0;
      end
      if (push_req) begin
        if (q.size() < DEPTH) q.push_back(Mem_WrData[7:0]);
        else ovf = 1'b1;
      end
      if (clr) ovf = 1'b0;
    end
    exp_tx = frame_bit();
  endtask

  task automatic drive(input logic rst, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] st);
    @(negedge clk);
    reset      = rst;
    MemWrite   = we;
    Mem_WrAddr = addr;
    Mem_WrData = data;
    Store      = st;
    #1;
  endtask

  task automatic check_comb();
    logic        hit;
    logic [31:0] exp_rd;
    if (comb_ok) begin
      hit    = (Mem_WrAddr[31:4] == BASE_HI);
      exp_rd = (hit && (Mem_WrAddr[3:2] == 2'd1)) ? model_status() : 32'h0;
      check("mmio_hit", 64'(mmio_hit), 64'(hit));
      check("dmem_we", 64'(dmem_we), 64'(MemWrite & ~hit));
      check("mmio_rdata", 64'(mmio_rdata), 64'(exp_rd));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("uart_tx", 64'(uart_tx), 64'(exp_tx));
    check("tx_irq", 64'(tx_irq), 64'(model_irq()));
    log_tx.push_back(uart_tx);
    log_irq.push_back(tx_irq);
    log_rd.push_back(mmio_rdata);
  endtask

  task automatic cycle(input logic rst, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] st);
    drive(rst, we, addr, data, st);
    check_comb();
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, BASE + 32'h4, 32'h0, 2'b00);
  endtask

  task automatic push_byte(input logic [7:0] b);
    cycle(1'b0, 1'b1, BASE, {24'hC0FFEE, b}, 2'($urandom_range(0, 3)));
  endtask

  task automatic clear_logs();
    log_tx.delete();
    log_irq.delete();
    log_rd.delete();
  endtask

  // Hang guard: a stuck run still reports and stops.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Directed sequences, decode table, then randomized traffic.
  initial begin
    vecs[0]  = '{1'b1, BASE + 32'h10, 32'h55, 1'b0, 1'b1, 32'h0};
    vecs[1]  = '{1'b1, BASE + 32'h8,  32'h55, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, BASE + 32'hC,  32'h0,  1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, BASE + 32'h4,  32'h0,  1'b1, 1'b0, 32'h4};
    vecs[4]  = '{1'b0, BASE + 32'h7,  32'h0,  1'b1, 1'b0, 32'h4};
    vecs[5]  = '{1'b1, BASE + 32'hC,  32'hFF, 1'b1, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, BASE - 32'h4,  32'h77, 1'b0, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, BASE,          32'h0,  1'b1, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, BASE + 32'h4,  32'hF7, 1'b1, 1'b0, 32'h4};
    vecs[9]  = '{1'b1, 32'h0000_0100, 32'h12, 1'b0, 1'b1, 32'h0};
    vecs[10] = '{1'b0, BASE + 32'h1F, 32'h0,  1'b0, 1'b0, 32'h0};

    // Reset state.
    cycle(1'b1, 1'b0, BASE + 32'h4, 32'h0, 2'b00);
    comb_ok = 1'b1;
    cycle(1'b1, 1'b0, BASE + 32'h4, 32'h0, 2'b00);
    drive(1'b0, 1'b0, BASE + 32'h4, 32'h0, 2'b00);
    check("reset_status", 64'(mmio_rdata), 64'h4);
    check("reset_irq", 64'(tx_irq), 64'h1);
    check("reset_tx", 64'(uart_tx), 64'h1);
    tick();

    // Decode and gating table; none of these rows may push.
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, vecs[i].we, vecs[i].addr, vecs[i].data, 2'b10);
      check($sformatf("vec%0d_hit", i), 64'(mmio_hit), 64'(vecs[i].exp_hit));
      check($sformatf("vec%0d_dmem_we", i), 64'(dmem_we), 64'(vecs[i].exp_we));
      check($sformatf("vec%0d_rdata", i), 64'(mmio_rdata), 64'(vecs[i].exp_rdata));
      tick();
    end
    drive(1'b0, 1'b0, BASE + 32'h4, 32'h0, 2'b00);
    check("decode_no_push", 64'(mmio_rdata), 64'h4);
    tick();

    // T1: single 0xA5 frame, start bit from E1, 40 cycles total.
    clear_logs();
    push_byte(8'hA5);
    idle(45);
    fbyte = 8'hA5;
    exp_f = '0;
    act_f = '0;
    for (int k = 1; k <= FRAME; k++) begin
      bi = (k - 1) / CPB;
      if (bi == 0) exp_f[k-1] = 1'b0;
      else if (bi == 9) exp_f[k-1] = 1'b1;
      else exp_f[k-1] = fbyte[bi-1];
      act_f[k-1] = log_tx[k];
    end
    check("t1_e0_still_idle_line", 64'(log_tx[0]), 64'h1);
    check("t1_frame", act_f, exp_f);
    check("t1_irq_in_stop", 64'(log_irq[40]), 64'h0);
    check("t1_irq_after", 64'(log_irq[41]), 64'h1);

    // T2: three pushes on consecutive cycles, frames chained without gaps.
    clear_logs();
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    idle(130);
    check("t2_count_2", 64'(log_rd[40][7:4]), 64'h2);
    check("t2_count_1", 64'(log_rd[41][7:4]), 64'h1);
    check("t2_count_1b", 64'(log_rd[80][7:4]), 64'h1);
    check("t2_count_0", 64'(log_rd[81][7:4]), 64'h0);
    check("t2_stop1", 64'(log_tx[40]), 64'h1);
    check("t2_start2", 64'(log_tx[41]), 64'h0);
    check("t2_start3", 64'(log_tx[81]), 64'h0);
    bad = 0;
    for (int k = 1; k <= 120; k++) if (log_irq[k] !== 1'b0) bad++;
    check("t2_no_gap", 64'(bad), 64'h0);
    check("t2_irq_end", 64'(log_irq[121]), 64'h1);

    // T3: six pushes in six cycles; the sixth overflows; then clear it.
    cycle(1'b1, 1'b0, BASE + 32'h4, 32'h0, 2'b00);
    for (int i = 0; i < 6; i++) push_byte(8'h10 + 8'(i));
    drive(1'b0, 1'b0, BASE + 32'h4, 32'h0, 2'b00);
    check("t3_status", 64'(mmio_rdata), 64'h4B);
    check_comb();
    tick();
    cycle(1'b0, 1'b1, BASE + 32'h4, 32'h8, 2'b10);
    drive(1'b0, 1'b0, BASE + 32'h4, 32'h0, 2'b00);
    check("t3_ovf_clear", 64'(mmio_rdata), 64'h43);
    check_comb();
    tick();
    idle(220);

    // T5: reset during data bit 3 with two bytes still queued.
    cycle(1'b1, 1'b0, BASE + 32'h4, 32'h0, 2'b00);
    clear_logs();
    push_byte(8'h3C);
    push_byte(8'h5A);
    push_byte(8'h99);
    idle(16);
    cycle(1'b1, 1'b0, BASE + 32'h4, 32'h0, 2'b00);
    check("t5_tx_high", 64'(log_tx[19]), 64'h1);
    drive(1'b0, 1'b0, BASE + 32'h4, 32'h0, 2'b00);
    check("t5_status", 64'(mmio_rdata), 64'h4);
    tick();
    idle(100);
    bad = 0;
    for (int k = 19; k < log_tx.size(); k++) begin
      if ((log_tx[k] !== 1'b1) || (log_irq[k] !== 1'b1)) bad++;
    end
    check("t5_quiet", 64'(bad), 64'h0);

    // T6: FIFO full at the end of STOP; a push on the pop edge is accepted.
    clear_logs();
    for (int i = 0; i < 5; i++) push_byte(8'hE0 + 8'(i));
    idle(36);
    push_byte(8'hE5);
    drive(1'b0, 1'b0, BASE + 32'h4, 32'h0, 2'b00);
    check("t6_status", 64'(mmio_rdata), 64'h43);
    tick();
    idle(210);
    check("t6_drained", 64'(tx_irq), 64'h1);

    // Randomized traffic in alternating heavy and light phases.
    for (int blk = 0; blk < 6; blk++) begin
      rate = (blk % 2 == 0) ? 30 : 4;
      for (int i = 0; i < 500; i++) begin
        sel = $urandom_range(0, 7);
        case (sel)
          0, 1, 2: r_addr = BASE + 32'($urandom_range(0, 3));
          3:       r_addr = BASE + 32'h4;
          4:       r_addr = BASE + 32'h8;
          5:       r_addr = BASE + 32'hC + 32'($urandom_range(0, 3));
          6:       r_addr = BASE + 32'h10;
          default: r_addr = $urandom();
        endcase
        r_we  = ($urandom_range(0, 99) < rate);
        r_rst = ($urandom_range(0, 399) == 0);
        cycle(r_rst, r_we, r_addr, $urandom(), 2'($urandom_range(0, 3)));
      end
    end
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
